// File: rtl/snes_pad_reader.sv
// Initiator for a SNES-style serial gamepad: polls periodically and returns an active-high button word.
// Optional SNES_PAD_DEBOUNCE_EN: buttons only change after two identical consecutive frames.
module snes_pad_reader #(
  parameter int CLK_DIV  = 150,
  parameter int POLL_DIV = 416667
) (
  input  logic        clock,
  input  logic        reset,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad_data,
  output logic [15:0] buttons,
  output logic        valid
);

  localparam int PH_W   = $clog2(2 * CLK_DIV);
  localparam int POLL_W = $clog2(POLL_DIV);

  localparam logic [PH_W-1:0]   PH_LATCH_END = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF_END  = PH_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST    = POLL_W'(POLL_DIV - 1);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("snes_pad_reader: CLK_DIV must be at least 4");
  end
  if (POLL_DIV <= 33 * CLK_DIV + 1) begin : g_bad_poll_div
    $error("snes_pad_reader: POLL_DIV too small to fit one frame");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [15:0]         shift_q, shift_d;
  logic                sync1_q, sync2_q;
  logic                pad_latch_q, pad_latch_d;
  logic                pad_clk_q, pad_clk_d;
  logic [15:0]         buttons_q, buttons_d;
  logic                valid_q, valid_d;
`ifdef SNES_PAD_DEBOUNCE_EN
  logic [15:0]         prev_q, prev_d;
`endif

  logic                start;
  logic [15:0]         frame;
  logic [15:0]         frame_inv;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ph_d        = ph_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    pad_latch_d = pad_latch_q;
    pad_clk_d   = pad_clk_q;
    buttons_d   = buttons_q;
    valid_d     = 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
    prev_d      = prev_q;
`endif

    start  = (poll_q == POLL_LAST);
    poll_d = start ? '0 : poll_q + POLL_W'(1);

    // Word as it will look once the bit being sampled this cycle is stored.
    frame            = shift_q;
    frame[bit_idx_q] = sync2_q;
    frame_inv        = ~frame;

    unique case (state_q)
      ST_IDLE: begin
        pad_latch_d = 1'b0;
        pad_clk_d   = 1'b1;
        if (start) begin
          state_d     = ST_LATCH;
          ph_d        = '0;
          pad_latch_d = 1'b1;
        end
      end

      ST_LATCH: begin
        if (ph_q == PH_LATCH_END) begin
          state_d     = ST_CLK_HI;
          ph_d        = '0;
          bit_idx_d   = 4'd0;
          pad_latch_d = 1'b0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      ST_CLK_HI: begin
        if (ph_q == PH_HALF_END) begin
          shift_d = frame;
          ph_d    = '0;
          if (bit_idx_q == 4'd15) begin
            // Outputs are registered, so the result is loaded on entry to DONE to show during DONE.
            state_d = ST_DONE;
            valid_d = 1'b1;
`ifdef SNES_PAD_DEBOUNCE_EN
            prev_d = frame_inv;
            if (frame_inv == prev_q) buttons_d = frame_inv;
`else
            buttons_d = frame_inv;
`endif
          end else begin
            state_d   = ST_CLK_LO;
            pad_clk_d = 1'b0;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      ST_CLK_LO: begin
        if (ph_q == PH_HALF_END) begin
          state_d   = ST_CLK_HI;
          ph_d      = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          pad_clk_d = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        pad_latch_d = 1'b0;
        pad_clk_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      poll_q      <= '0;
      ph_q        <= '0;
      bit_idx_q   <= 4'd0;
      // NOTE: the shift register is reset too; it is only 16 flops, not a RAM, so this costs nothing.
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      buttons_q   <= '0;
      valid_q     <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
      prev_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      poll_q      <= poll_d;
      ph_q        <= ph_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      sync1_q     <= pad_data;
      sync2_q     <= sync1_q;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      buttons_q   <= buttons_d;
      valid_q     <= valid_d;
`ifdef SNES_PAD_DEBOUNCE_EN
      prev_q      <= prev_d;
`endif
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Self-checking bench for snes_pad_reader with a behavioural pad and a frame-level reference model.
module tb_snes_pad_reader;

  localparam int D     = 4;
  localparam int POLL  = 200;
  localparam int FRAME = 33 * D;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data;
  logic [15:0] buttons;
  logic        valid;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int last_latch;
  int last_valid;

  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sr   = 16'hFFFF;
  logic [15:0] exp_btn  = 16'h0000;
  logic [15:0] exp_prev = 16'h0000;

  always #5 clock = ~clock;

  snes_pad_reader #(.CLK_DIV(D), .POLL_DIV(POLL)) dut (
    .clock     (clock),
    .reset     (reset),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .buttons   (buttons),
    .valid     (valid)
  );

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // Pad: loads its word while latch is high, shifts on each rising pad_clk, 1s fill behind.
  always @(posedge pad_clk or posedge pad_latch)
    if (pad_latch) pad_sr <= pad_word;
    else           pad_sr <= {1'b1, pad_sr[15:1]};
  assign pad_data = pad_sr[0];

  // Frame-level reference: buttons follow the inverted wire word, optionally after two equal frames.
  task automatic model_frame(input logic [15:0] wire_word);
`ifdef SNES_PAD_DEBOUNCE_EN
    if (~wire_word == exp_prev) exp_btn = ~wire_word;
    exp_prev = ~wire_word;
`else
    exp_btn = ~wire_word;
`endif
  endtask

  task automatic model_reset();
    exp_btn  = 16'h0000;
    exp_prev = 16'h0000;
  endtask

  // Observe one frame from idle: latch rise, clock falls, valid strobe and captured buttons.
  task automatic wait_frame(output int t_latch, output int t_valid, output int n_falls,
                            output int gap_falls, output int latch_len, output int valid_cnt,
                            output logic [15:0] btn, output bit ok);
    int   guard;
    logic prev_clk;
    ok = 1'b1; t_latch = -1; t_valid = -1; n_falls = 0; gap_falls = 0;
    latch_len = 0; valid_cnt = 0; btn = 'x;
    prev_clk = pad_clk;
    guard = 0;
    while (pad_latch !== 1'b1 && guard < 2 * POLL) begin
      @(negedge clock);
      guard++;
      if (prev_clk === 1'b1 && pad_clk === 1'b0) gap_falls++;
      prev_clk = pad_clk;
    end
    if (pad_latch !== 1'b1) begin ok = 1'b0; return; end
    t_latch = cyc;
    latch_len = 1;
    guard = 0;
    while (valid !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge clock);
      guard++;
      if (pad_latch === 1'b1) latch_len++;
      if (prev_clk === 1'b1 && pad_clk === 1'b0) n_falls++;
      prev_clk = pad_clk;
    end
    if (valid !== 1'b1) begin ok = 1'b0; return; end
    t_valid   = cyc;
    btn       = buttons;
    valid_cnt = 1;
    @(negedge clock);
    if (valid === 1'b1) valid_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (pad_latch !== 1'b0)      begin failures++; $display("FAIL rst_latch: got %b want 0", pad_latch); end
    checks++; if (pad_clk !== 1'b1)        begin failures++; $display("FAIL rst_clk: got %b want 1", pad_clk); end
    checks++; if (buttons !== 16'h0000)    begin failures++; $display("FAIL rst_buttons: got %h want 0000", buttons); end
    checks++; if (valid !== 1'b0)          begin failures++; $display("FAIL rst_valid: got %b want 0", valid); end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_idle_then_latch();
    int t_l, t_v, nf, gf, ll, vc; logic [15:0] b; bit ok;
    pad_word = 16'hFFFF;
    for (int i = 1; i < POLL; i++) begin
      @(negedge clock);
      checks++;
      if ({pad_latch, pad_clk, valid, buttons} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
        failures++;
        $display("FAIL idle_hold cyc %0d: got latch=%b clk=%b valid=%b buttons=%h want 0 1 0 0000",
                 cyc, pad_latch, pad_clk, valid, buttons);
      end
    end
    wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
    model_frame(pad_word);
    checks++; if (!ok)         begin failures++; $display("FAIL first_frame_timeout: got ok=0 want 1"); end
    checks++; if (t_l != POLL) begin failures++; $display("FAIL first_latch_cycle: got %0d want %0d", t_l, POLL); end
    checks++; if (ll != 2 * D) begin failures++; $display("FAIL latch_len: got %0d want %0d", ll, 2 * D); end
    checks++; if (b !== exp_btn) begin failures++; $display("FAIL first_buttons: got %h want %h", b, exp_btn); end
    last_latch = t_l;
    last_valid = t_v;
  endtask

  task automatic test_b_start();
    int t_l, t_v, nf, gf, ll, vc; logic [15:0] b; bit ok;
    pad_word = 16'hFFF6;
    wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
    model_frame(pad_word);
    checks++; if (!ok)                      begin failures++; $display("FAIL bs_timeout: got ok=0 want 1"); end
    checks++; if (t_l != last_latch + POLL) begin failures++; $display("FAIL bs_period: got %0d want %0d", t_l, last_latch + POLL); end
    checks++; if (nf != 15)                 begin failures++; $display("FAIL bs_clk_falls: got %0d want 15", nf); end
    checks++; if (t_v - t_l != FRAME)       begin failures++; $display("FAIL bs_valid_delay: got %0d want %0d", t_v - t_l, FRAME); end
    checks++; if (vc != 1)                  begin failures++; $display("FAIL bs_valid_width: got %0d want 1", vc); end
    checks++; if (b !== exp_btn)            begin failures++; $display("FAIL bs_buttons: got %h want %h", b, exp_btn); end
    last_latch = t_l;
    last_valid = t_v;
  endtask

  task automatic test_no_press();
    int t_l, t_v, nf, gf, ll, vc; logic [15:0] b; bit ok;
    pad_word = 16'hFFFF;
    for (int f = 0; f < 3; f++) begin
      wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
      model_frame(pad_word);
      checks++; if (!ok)                      begin failures++; $display("FAIL np_timeout: got ok=0 want 1"); end
      checks++; if (b !== exp_btn)            begin failures++; $display("FAIL np_buttons: got %h want %h", b, exp_btn); end
      checks++; if (t_v != last_valid + POLL) begin failures++; $display("FAIL np_valid_period: got %0d want %0d", t_v, last_valid + POLL); end
      checks++; if (gf != 0)                  begin failures++; $display("FAIL np_gap_glitch: got %0d falls want 0", gf); end
      checks++; if (vc != 1)                  begin failures++; $display("FAIL np_valid_width: got %0d want 1", vc); end
      last_latch = t_l;
      last_valid = t_v;
    end
  endtask

  task automatic test_reset_mid_frame();
    int t_l, t_v, nf, gf, ll, vc, guard; logic [15:0] b; bit ok;
    pad_word = 16'h5A5A;
    wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
    model_frame(pad_word);
    checks++; if (b !== exp_btn) begin failures++; $display("FAIL rm_pre_buttons: got %h want %h", b, exp_btn); end
    guard = 0;
    while (pad_latch !== 1'b1 && guard < 2 * POLL) begin @(negedge clock); guard++; end
    checks++; if (pad_latch !== 1'b1) begin failures++; $display("FAIL rm_latch_timeout: got %b want 1", pad_latch); end
    // Bit 7 high phase spans latch+64 .. latch+67.
    repeat (66) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (pad_latch !== 1'b0)   begin failures++; $display("FAIL rm_latch: got %b want 0", pad_latch); end
    checks++; if (pad_clk !== 1'b1)     begin failures++; $display("FAIL rm_clk: got %b want 1", pad_clk); end
    checks++; if (buttons !== 16'h0000) begin failures++; $display("FAIL rm_buttons: got %h want 0000", buttons); end
    checks++; if (valid !== 1'b0)       begin failures++; $display("FAIL rm_valid: got %b want 0", valid); end
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    pad_word = 16'($urandom);
    wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
    model_frame(pad_word);
    checks++; if (!ok)                begin failures++; $display("FAIL rm_timeout: got ok=0 want 1"); end
    checks++; if (t_l != POLL)        begin failures++; $display("FAIL rm_latch_cycle: got %0d want %0d", t_l, POLL); end
    checks++; if (nf != 15)           begin failures++; $display("FAIL rm_clk_falls: got %0d want 15", nf); end
    checks++; if (t_v - t_l != FRAME) begin failures++; $display("FAIL rm_valid_delay: got %0d want %0d", t_v - t_l, FRAME); end
    checks++; if (b !== exp_btn)      begin failures++; $display("FAIL rm_buttons_after: got %h want %h", b, exp_btn); end
    last_latch = t_l;
    last_valid = t_v;
  endtask

  task automatic test_all_bits();
    int t_l, t_v, nf, gf, ll, vc, nrep; logic [15:0] b; bit ok;
    logic [15:0] pats [2];
    pats[0] = 16'hF000;
    pats[1] = 16'hFFFF;
`ifdef SNES_PAD_DEBOUNCE_EN
    nrep = 2;
`else
    nrep = 1;
`endif
    for (int p = 0; p < 2; p++) begin
      pad_word = pats[p];
      for (int r = 0; r < nrep; r++) begin
        wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
        model_frame(pad_word);
        checks++; if (!ok)           begin failures++; $display("FAIL ab_timeout: got ok=0 want 1"); end
        checks++; if (b !== exp_btn) begin failures++; $display("FAIL ab_buttons pat %0d: got %h want %h", p, b, exp_btn); end
      end
    end
  endtask

`ifdef SNES_PAD_DEBOUNCE_EN
  task automatic test_debounce();
    int t_l, t_v, nf, gf, ll, vc; logic [15:0] b; bit ok;
    logic [15:0] seq_word [4];
    logic [15:0] seq_exp  [4];
    seq_word[0] = 16'hFEFF; seq_exp[0] = 16'h0000;
    seq_word[1] = 16'hFFFF; seq_exp[1] = 16'h0000;
    seq_word[2] = 16'hFEFF; seq_exp[2] = 16'h0000;
    seq_word[3] = 16'hFEFF; seq_exp[3] = 16'h0100;
    for (int f = 0; f < 4; f++) begin
      pad_word = seq_word[f];
      wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
      model_frame(pad_word);
      checks++; if (!ok)              begin failures++; $display("FAIL db_timeout: got ok=0 want 1"); end
      checks++; if (b !== seq_exp[f]) begin failures++; $display("FAIL db_buttons frame %0d: got %h want %h", f, b, seq_exp[f]); end
      checks++; if (vc != 1)          begin failures++; $display("FAIL db_valid_width: got %0d want 1", vc); end
    end
  endtask
`endif

  task automatic test_random();
    int t_l, t_v, nf, gf, ll, vc, prev_l; logic [15:0] b; bit ok;
    prev_l = -1;
    for (int f = 0; f < 6; f++) begin
      pad_word = (f % 3 == 2) ? pad_word : 16'($urandom);
      wait_frame(t_l, t_v, nf, gf, ll, vc, b, ok);
      model_frame(pad_word);
      checks++; if (!ok)                begin failures++; $display("FAIL rnd_timeout: got ok=0 want 1"); end
      checks++; if (b !== exp_btn)      begin failures++; $display("FAIL rnd_buttons word %h: got %h want %h", pad_word, b, exp_btn); end
      checks++; if (t_v - t_l != FRAME) begin failures++; $display("FAIL rnd_valid_delay: got %0d want %0d", t_v - t_l, FRAME); end
      checks++; if (nf != 15)           begin failures++; $display("FAIL rnd_clk_falls: got %0d want 15", nf); end
      if (prev_l >= 0) begin
        checks++; if (t_l - prev_l != POLL) begin failures++; $display("FAIL rnd_period: got %0d want %0d", t_l - prev_l, POLL); end
      end
      prev_l = t_l;
    end
  endtask

  initial begin
    test_reset();
    test_idle_then_latch();
    test_b_start();
    test_no_press();
    test_reset_mid_frame();
    test_all_bits();
`ifdef SNES_PAD_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
